ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_pkg.sv | 23 ++
 rtl/ram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
// Covers the return-data routing choice and the output-pipeline occupancy count.
package ram_fifo_ctrl_pkg;

    // Where a word returning from the RAM read port lands this cycle.
    typedef enum logic [1:0] {
        RET_NONE,
        RET_TO_OUT,
        RET_TO_PIPE
    } ret_route_e;

    // Words committed to the output pipeline once this cycle's pop is taken out.
    // pop implies m_valid, so the subtraction never underflows.
    function automatic logic [1:0] pipe_count(
        input logic rd_pend,
        input logic pipe_valid,
        input logic m_valid,
        input logic pop
    );
        return {1'b0, rd_pend} + {1'b0, pipe_valid} + {1'b0, m_valid} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller over an external dual-port RAM with a 1-cycle registered read.
// A two-entry output pipeline (pipe + output register) hides the RAM read latency.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  rd_pend;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    logic       empty;
    logic       full;
    logic       wr_fire;
    logic       pop;
    logic       advance;
    logic       rd_issue;
    ret_route_e route;

    // The extra pointer MSB separates full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign s_ready     = !full && !rst;
    assign wr_fire     = s_valid && s_ready;
    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = s_data;

    assign pop     = m_valid && m_ready;
    assign advance = !m_valid || pop;

    // Empty is judged on the registered wr_ptr, so a read never targets this cycle's write.
    assign rd_issue    = !empty && (pipe_count(rd_pend, pipe_valid, m_valid, pop) < 2'd2);
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    assign level = wr_ptr - rd_ptr;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        route = RET_NONE;
        if (rd_pend) begin
            route = (!pipe_valid && advance) ? RET_TO_OUT : RET_TO_PIPE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            pipe_valid <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_pend <= rd_issue;

            // A held pipe word always moves out ahead of a newly returning word.
            if (advance) begin
                if (pipe_valid) begin
                    m_data  <= pipe_data;
                    m_valid <= 1'b1;
                end else if (route == RET_TO_OUT) begin
                    m_data  <= ram_rd_data;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end

            pipe_valid <= (pipe_valid && !advance) || (route == RET_TO_PIPE);
        end
    end

    // NOTE: pure data registers carry no reset; pipe_valid alone decides whether pipe_data means anything.
    always_ff @(posedge clk) begin
        if (route == RET_TO_PIPE) begin
            pipe_data <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM and a queue reference model.
// A background monitor checks ordering, stall stability and level/ready consistency every cycle.
module tb_ram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [AW:0]   level;

    logic [DW-1:0] mem [DEPTH];

    int          vectors     = 0;
    int          miscompares = 0;
    int          rx_count    = 0;
    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .level      (level)
    );

    // Dual-port RAM: port A writes, port B reads with one registered cycle of latency.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted word must come out once, in order; level is RAM-held words only.
    task automatic monitor();
        logic          stall_prev;
        logic [DW-1:0] stall_data;
        logic [DW-1:0] exp_word;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_q.delete();
                stall_prev = 1'b0;
            end else begin
                vectors++;
                if (int'(level) > DEPTH || s_ready !== (int'(level) != DEPTH)) begin
                    miscompares++;
                    $display("FAIL mon_full_flag: level=%0d s_ready=%b", level, s_ready);
                end
                vectors++;
                if (int'(level) > model_q.size() || model_q.size() > int'(level) + 2) begin
                    miscompares++;
                    $display("FAIL mon_level: level=%0d outstanding=%0d", level, model_q.size());
                end
                if (stall_prev) begin
                    vectors++;
                    if (m_valid !== 1'b1 || m_data !== stall_data) begin
                        miscompares++;
                        $display("FAIL mon_stall: m_valid=%b m_data=%h held=%h", m_valid, m_data, stall_data);
                    end
                end
                if (m_valid && m_ready) begin
                    vectors++;
                    rx_count++;
                    if (model_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL mon_spurious: got %h with nothing outstanding", m_data);
                    end else begin
                        exp_word = model_q.pop_front();
                        if (m_data !== exp_word) begin
                            miscompares++;
                            $display("FAIL mon_order: got %h want %h", m_data, exp_word);
                        end
                    end
                end
                if (s_valid && s_ready) model_q.push_back(s_data);
                stall_prev = m_valid && !m_ready;
                stall_data = m_data;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: s_ready=%b want 0", s_ready);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== '0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b level=%0d m_data=%h want 1 0 0 0000",
                     s_ready, m_valid, level, m_data);
        end
    endtask

    task automatic test_latency();
        logic [AW:0] exp_level [4];
        logic        exp_valid [5];
        exp_level = '{0, 1, 0, 0};
        exp_valid = '{0, 0, 0, 1, 0};
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            s_valid = (c == 0);
            s_data  = (c == 0) ? 16'h1234 : 16'h0000;
            m_ready = 1'b1;
            @(negedge clk);
            if (c < 4) begin
                vectors++;
                if (level !== exp_level[c]) begin
                    miscompares++;
                    $display("FAIL latency_level c%0d: level=%0d want %0d", c, level, exp_level[c]);
                end
            end
            vectors++;
            if (m_valid !== exp_valid[c] || (exp_valid[c] && m_data !== 16'h1234)) begin
                miscompares++;
                $display("FAIL latency_out c%0d: m_valid=%b m_data=%h want %b 1234",
                         c, m_valid, m_data, exp_valid[c]);
            end
        end
    endtask

    task automatic test_fill_full();
        int accepted;
        int rx_start;
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            s_valid = 1'b1;
            s_data  = 16'h0100 + 16'(c);
            m_ready = 1'b0;
            @(negedge clk);
            if (!s_ready) break;
            accepted++;
        end
        vectors++;
        if (accepted != DEPTH + 2 || level !== (AW+1)'(DEPTH) || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: accepted=%0d level=%0d m_valid=%b want %0d %0d 1",
                     accepted, level, m_valid, DEPTH + 2, DEPTH);
        end
        rx_start = rx_count;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            s_valid = 1'b0;
            m_ready = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (rx_count - rx_start != DEPTH + 2 || level !== '0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_drain: drained=%0d level=%0d m_valid=%b want %0d 0 0",
                     rx_count - rx_start, level, m_valid, DEPTH + 2);
        end
    endtask

    // Continuous stream: word c is written in cycle c and must be on m_data in cycle c+3.
    task automatic test_back_to_back();
        for (int c = 0; c <= 1003; c++) begin
            next_cycle();
            s_valid = (c < 1000);
            s_data  = 16'(c);
            m_ready = 1'b1;
            @(negedge clk);
            if (c < 1000) begin
                vectors++;
                if (s_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ready c%0d: s_ready=%b want 1", c, s_ready);
                end
            end
            if (c >= 3) begin
                vectors++;
                if (c < 1003 && (m_valid !== 1'b1 || m_data !== 16'(c - 3))) begin
                    miscompares++;
                    $display("FAIL stream_out c%0d: m_valid=%b m_data=%h want 1 %h", c, m_valid, m_data, 16'(c - 3));
                end else if (c == 1003 && m_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_end: m_valid=%b want 0", m_valid);
                end
            end
        end
        next_cycle();
        s_valid = 1'b0;
    endtask

    task automatic run_traffic(input string name, input int words, input bit random_ready, input int budget);
        int sent;
        int rx_start;
        int cyc;
        sent     = 0;
        rx_start = rx_count;
        cyc      = 0;
        while (rx_count - rx_start < words && cyc < budget) begin
            next_cycle();
            s_valid = (sent < words) && (!random_ready || $urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            cyc++;
        end
        vectors++;
        if (rx_count - rx_start != words || sent != words || model_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_complete: sent=%0d received=%0d outstanding=%0d want %0d %0d 0",
                     name, sent, rx_count - rx_start, model_q.size(), words, words);
        end
        next_cycle();
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_random_stall();
        run_traffic("random", 500, 1'b1, 8000);
    endtask

    task automatic test_wrap();
        run_traffic("wrap", 20, 1'b0, 400);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            s_valid = 1'b1;
            s_data  = 16'h0A00 + 16'(c);
            m_ready = 1'b0;
        end
        next_cycle();
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ready: s_ready=%b want 0", s_ready);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0 || level !== '0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_state: m_valid=%b level=%0d s_ready=%b want 0 0 1", m_valid, level, s_ready);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            s_valid = (c == 0);
            s_data  = 16'hBEEF;
            m_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (c < 3 && m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_stale c%0d: m_valid=%b m_data=%h want 0", c, m_valid, m_data);
            end else if (c == 3 && (m_valid !== 1'b1 || m_data !== 16'hBEEF)) begin
                miscompares++;
                $display("FAIL midreset_first: m_valid=%b m_data=%h want 1 beef", m_valid, m_data);
            end
        end
        next_cycle();
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_latency();
        test_fill_full();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        test_wrap();
        repeat (3) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
